// File: rtl/mod_unit.sv
// -----------------------------------------------------------------------------
// mod_unit -- sequential modular-reduction responder.
//
// Reduces a signed 128-bit operand to its canonical residue in [0, PRIME-1]
// with a bit-serial restoring shift-subtract loop that consumes one operand
// bit per cycle, MSB first. A request is accepted in IDLE. The block then
// spends 128 cycles in RUN and 1 cycle in FIX, and pulses moddone for 1 cycle
// in DONE before returning to IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active HIGH (name kept for the codebase)
//   helpmod    request strobe, level-sensitive, honoured only in IDLE
//   mod_a      128-bit operand (two's complement when neg_mod_a=1)
//   neg_mod_a  operand sign
//   mod_result 64-bit residue, updated only on FIX->DONE, held afterwards
//   moddone    one-cycle registered completion pulse
// -----------------------------------------------------------------------------
module mod_unit #(
   parameter logic [63:0] PRIME = 64'd18446744073709551557
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         helpmod,
   input  logic [127:0] mod_a,
   input  logic         neg_mod_a,
   output logic [63:0]  mod_result,
   output logic         moddone
);

   localparam int DATA_W = 64;
   localparam int OPND_W = 128;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [6:0]          cnt;
   logic [DATA_W-1:0]   r;
   logic [DATA_W-1:0]   res;
   logic [OPND_W-1:0]   mag;
   logic                sign;

   // Magnitude of the operand. Negating -2^127 wraps back to the 2^127 bit
   // pattern, which is the correct magnitude when read as unsigned.
   function automatic logic [OPND_W-1:0] magnitude(
      input logic signed [OPND_W-1:0] opnd,
      input logic                     neg
   );
      logic signed [OPND_W-1:0] m;
      m = neg ? -opnd : opnd;
      return m;
   endfunction

   // One restoring step: shift in the next bit, subtract PRIME if it fits.
   // acc < PRIME on entry, so the 65-bit value is < 2*PRIME and a single
   // conditional subtract restores acc < PRIME.
   function automatic logic [DATA_W-1:0] reduce_step(
      input logic [DATA_W-1:0] acc,
      input logic              bit_in
   );
      logic [DATA_W:0] t;
      logic [DATA_W:0] d;
      t = {acc, bit_in};
      d = t - {1'b0, PRIME};
      if (t >= {1'b0, PRIME}) return d[DATA_W-1:0];
      return t[DATA_W-1:0];
   endfunction

   // Fold the sign back in. A zero residue stays zero for either sign.
   function automatic logic [DATA_W-1:0] canon(
      input logic [DATA_W-1:0] acc,
      input logic              neg
   );
      if (neg && (acc != '0)) return PRIME - acc;
      return acc;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (helpmod) state_nxt = RUN;
         RUN:     if (cnt == 7'd0) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch: pure data, captured only on the accepting edge
   always_ff @(posedge clk) begin
      if ((state == IDLE) && helpmod && !rst_n)
         mag <= magnitude(mod_a, neg_mod_a);
   end

   // Reduction loop, result register and completion pulse
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r       <= '0;
         cnt     <= '0;
         sign    <= 1'b0;
         res     <= '0;
         moddone <= 1'b0;
      end else begin
         // Registered decode of "entering DONE": never glitches, one cycle wide
         moddone <= (state == FIX);
         case (state)
            IDLE: begin
               if (helpmod) begin
                  sign <= neg_mod_a;
                  r    <= '0;
                  cnt  <= 7'd127;
               end
            end
            RUN: begin
               r   <= reduce_step(r, mag[cnt]);
               cnt <= cnt - 7'd1;
            end
            FIX:     res <= canon(r, sign);
            default: ;
         endcase
      end
   end

   assign mod_result = res;

endmodule

// File: doc/mod_unit.md
# mod_unit

Sequential modular-reduction responder for the point add/double datapath. It serves the `helpmod`/`moddone` request channel driven by the add/double controller. Each request carries a signed 128-bit operand, typically a raw 128-bit product or a 64-bit difference. The block returns the canonical residue in [0, PRIME-1] as a 64-bit value, using a bit-serial restoring shift-subtract loop (one operand bit per cycle).

## Interface
- `PRIME`, default 64'd18446744073709551557 (2^64-59): field modulus; must be odd and > 2^63.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-high (`rst_n`=1 at a rising edge resets); name kept per codebase port naming.
- `helpmod`  input  1  request strobe; accepted only in IDLE.
- `mod_a`  input  128  operand, two's complement when `neg_mod_a`=1, unsigned otherwise; sampled only on the accepting edge.
- `neg_mod_a`  input  1  operand sign.
- `mod_result`  output  64  residue; valid when `moddone`=1, held until the next accepted request.
- `moddone`  output  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE -> RUN on `helpmod`=1.
  - RUN holds for 128 cycles (7-bit counter 127..0), then goes to FIX.
  - FIX -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle.
- Accept (IDLE & `helpmod`):
  - sign <= `neg_mod_a`.
  - mag <= `neg_mod_a` ? (~`mod_a` + 1) : `mod_a`, as a 128-bit unsigned value.
  - mag = 2^127 (from `mod_a`=128'h8000…0 with neg=1) is legal.
  - r <= 0, cnt <= 127.
- RUN, each cycle:
  - t = {r, mag[cnt]}, 65 bits.
  - r <= (t >= PRIME) ? t - PRIME : t.
  - cnt decrements.
  - Invariant: r < PRIME after every step.
- FIX:
  - res <= (sign && r != 0) ? PRIME - r : r.
  - Zero magnitude gives 0 regardless of sign.
- DONE: `moddone`=1 and `mod_result`=res.
- The operand is fully latched, so the initiator may change `mod_a`/`neg_mod_a` after the accepting edge.
- `helpmod` in RUN, FIX or DONE is ignored: no queuing, no restart, no effect on the current result.
- `helpmod` held high across DONE→IDLE is accepted again in IDLE (level-sensitive). Initiators must drop it after `moddone`.
- No overflow or error condition exists; every 128-bit input with either sign yields a defined residue.

## Timing
- Reset values: `moddone`=0, `mod_result`=0, state=IDLE, r=0, cnt=0, sign=0.
- Reset mid-operation: state returns to IDLE on that edge. No `moddone` pulse is produced for the aborted request, and `mod_result` is 0.
- Latency: with `helpmod` sampled at edge E0, RUN occupies cycles 1–128, FIX is cycle 129, and `moddone`=1 during cycle 130 only.
  - The earliest next acceptance is at the end of cycle 131, in IDLE.
- `mod_result` changes only in the FIX→DONE update. It keeps its value through IDLE until the next FIX, so the initiator may sample it in the `moddone` cycle or any later cycle.
- `moddone` is a registered state decode, glitch-free, and never high two consecutive cycles.
- The 65-bit compare/subtract is the critical path; it has no multi-cycle allowance.

## Test plan
- Positive and wrap cases, `neg_mod_a`=0:
  - `mod_a`=100 -> `mod_result`=100, with `moddone` high exactly in cycle 130 after acceptance and low otherwise.
  - `mod_a`=PRIME -> 0.
  - `mod_a`=PRIME+5 -> 5.
  - `mod_a`=2^128-1 -> 3480, since 2^64 ≡ 59 and 2^128 ≡ 3481.
- Product case: `mod_a`=(PRIME-1)^2 = 128-bit product, `neg_mod_a`=0 -> 1.
- Negative cases, `neg_mod_a`=1:
  - `mod_a`=-7 (128'hFFFF…FFF9) -> 18446744073709551550.
  - `mod_a`=0 -> 0.
  - `mod_a`=128'h8000…0 -> 2^127 mod PRIME computed by reference model.
- Busy and reuse:
  - A second `helpmod` at cycle 60 with a different operand is ignored; only the first result appears, once.
  - Changing `mod_a` after acceptance does not alter the result.
  - Back-to-back requests with `helpmod` re-asserted in IDLE complete 131 cycles apart.
- Reset mid-run: assert `rst_n`=1 at cycle 50. The block shows `moddone`=0 and `mod_result`=0 from the next edge, and no pulse follows. A fresh request for 100 then completes normally in 130 cycles.
- Random regression: 10k random (`mod_a`, `neg_mod_a`) pairs against a big-integer model. The bench checks the result, that exactly one `moddone` pulse occurs per accepted request, and that `mod_result` stays stable between pulses.
